// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM datapath and its downstream accumulate/activate stage.
// Contents: lane-count and width constants, accumulator FSM state encoding, lane-vector types.
package mvm_pkg;

  localparam int LANES = 4;
  localparam int IN_W  = 4;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    BIAS,
    OUT
  } acc_state_e;

  // Lane vectors are packed with lane 0 in the least-significant slice.
  typedef logic [LANES*IN_W-1:0]  wx_vec_t;
  typedef logic [LANES*ACC_W-1:0] acc_vec_t;

endpackage

// File: rtl/mvm_requant.sv
// Per-lane requantiser: saturating signed bias add, ReLU, arithmetic right shift and
// unsigned saturation to OUT_W bits.
// Ports:
//   acc  in  ACC_W  signed accumulated sum
//   bias in  ACC_W  signed per-lane bias
//   data out OUT_W  requantised activation
//   ovf  out 1      bias add or output range saturated
module mvm_requant #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 2,
  parameter int OUT_W = 4
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] bias,
  output logic [OUT_W-1:0] data,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] R_MAX = ACC_W'((1 << OUT_W) - 1);

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] r;
  logic             add_sat;
  logic             out_sat;

  always_comb begin
    // Sign-extend both operands one bit so signed overflow shows up as a
    // disagreement between the top two bits.
    sum     = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
    add_sat = 1'b0;
    s       = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      add_sat = 1'b1;
      s       = sum[ACC_W] ? S_MIN : S_MAX;
    end

    // Negative sums clamp to zero; non-negative ones have a clear sign bit,
    // so a logical shift equals the arithmetic one.
    r = s[ACC_W-1] ? '0 : (s >> SHIFT);

    out_sat = 1'b0;
    data    = r[OUT_W-1:0];
    if (r > R_MAX) begin
      out_sat = 1'b1;
      data    = '1;
    end

    ovf = add_sat | out_sat;
  end

endmodule

// File: rtl/mvm_accum_act.sv
// Accumulates N_TILES per-lane unsigned partial products into saturating signed accumulators,
// then adds bias, applies ReLU and requantises into one OUT_W-bit value per lane, offered
// downstream over a valid/ready handshake.
// Ports:
//   i_clk_acc      in  clock, rising edge
//   i_rst_n_acc    in  asynchronous active-low reset
//   i_start_acc    in  start a new vector (accepted in IDLE, or in OUT with ready)
//   i_wx_valid_acc in  partial result valid (used in ACCUM only)
//   i_wx_acc       in  LANES x IN_W unsigned partial results
//   i_bias_acc     in  LANES x ACC_W signed biases, sampled in BIAS
//   i_ready_acc    in  downstream ready
//   o_busy_acc     out state is not IDLE
//   o_valid_acc    out o_data_acc valid
//   o_data_acc     out LANES x OUT_W activations
//   o_ovf_acc      out sticky saturation flag, cleared by an accepted start
module mvm_accum_act
  import mvm_pkg::*;
#(
  parameter int LANES   = mvm_pkg::LANES,
  parameter int IN_W    = mvm_pkg::IN_W,
  parameter int ACC_W   = mvm_pkg::ACC_W,
  parameter int N_TILES = 4,
  parameter int SHIFT   = 2,
  parameter int OUT_W   = 4
) (
  input  logic                   i_clk_acc,
  input  logic                   i_rst_n_acc,
  input  logic                   i_start_acc,
  input  logic                   i_wx_valid_acc,
  input  logic [LANES*IN_W-1:0]  i_wx_acc,
  input  logic [LANES*ACC_W-1:0] i_bias_acc,
  input  logic                   i_ready_acc,
  output logic                   o_busy_acc,
  output logic                   o_valid_acc,
  output logic [LANES*OUT_W-1:0] o_data_acc,
  output logic                   o_ovf_acc
);

  localparam int CNT_W = $clog2(N_TILES + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TILES - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};

  acc_state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q  [LANES];
  logic [ACC_W-1:0] acc_nx [LANES];
  logic [LANES-1:0] acc_sat;
  logic [CNT_W-1:0] cnt_q;
  logic [LANES*OUT_W-1:0] data_q;
  logic                   ovf_q;

  logic [LANES*OUT_W-1:0] rq_data;
  logic [LANES-1:0]       rq_ovf;

  logic clr;
  logic acc_en;
  logic bias_ld;

  always_ff @(posedge i_clk_acc or negedge i_rst_n_acc) begin
    if (!i_rst_n_acc) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    bias_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start_acc) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (i_wx_valid_acc) begin
          acc_en = 1'b1;
          if (cnt_q == LAST_CNT) state_d = BIAS;
        end
      end
      BIAS: begin
        bias_ld = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (i_ready_acc) begin
          if (i_start_acc) begin
            clr     = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Partial results are unsigned, so only positive overflow is possible.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      logic [ACC_W:0] sum;
      sum = {acc_q[l][ACC_W-1], acc_q[l]}
          + (ACC_W+1)'(i_wx_acc[l*IN_W +: IN_W]);
      acc_sat[l] = (sum[ACC_W] != sum[ACC_W-1]);
      acc_nx[l]  = acc_sat[l] ? ACC_MAX : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge i_clk_acc or negedge i_rst_n_acc) begin
    if (!i_rst_n_acc) begin
      for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (clr) begin
        for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (acc_en) begin
        for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= acc_nx[l];
        cnt_q <= cnt_q + 1'b1;
        if (|acc_sat) ovf_q <= 1'b1;
      end
      if (bias_ld) begin
        data_q <= rq_data;
        if (|rq_ovf) ovf_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_rq
    mvm_requant #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
    ) u_rq (
      .acc  (acc_q[g]),
      .bias (i_bias_acc[g*ACC_W +: ACC_W]),
      .data (rq_data[g*OUT_W +: OUT_W]),
      .ovf  (rq_ovf[g])
    );
  end

  assign o_busy_acc  = (state_q != IDLE);
  assign o_valid_acc = (state_q == OUT);
  assign o_data_acc  = data_q;
  assign o_ovf_acc   = ovf_q;

endmodule

// File: tb/tb_mvm_accum_act.sv
// Directed self-checking bench for mvm_accum_act (LANES=4, IN_W=4, N_TILES=4, SHIFT=2, OUT_W=4).
module tb_mvm_accum_act;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        wx_valid;
  logic [15:0] wx;
  logic [63:0] bias;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [15:0] data;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] BIAS_ZERO = 64'h0;
  // lanes 0..3 = -40, +40, 0, +4
  localparam logic [63:0] BIAS_MIX  = {16'sd4, 16'sd0, 16'sd40, -16'sd40};

  mvm_accum_act #(
    .LANES   (4),
    .IN_W    (4),
    .ACC_W   (16),
    .N_TILES (4),
    .SHIFT   (2),
    .OUT_W   (4)
  ) dut (
    .i_clk_acc      (clk),
    .i_rst_n_acc    (rst_n),
    .i_start_acc    (start),
    .i_wx_valid_acc (wx_valid),
    .i_wx_acc       (wx),
    .i_bias_acc     (bias),
    .i_ready_acc    (ready),
    .o_busy_acc     (busy),
    .o_valid_acc    (valid),
    .o_data_acc     (data),
    .o_ovf_acc      (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sends four beats; returns just after the edge that captured the last one.
  task automatic send_beats(input logic [15:0] v, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      wx_valid = 1'b1;
      wx       = v;
      step();
      wx_valid = 1'b0;
      if (gaps && i < 3) step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; wx_valid = 0; wx = '0; bias = '0; ready = 0;
    #2;
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (data !== 16'h0)  begin n_fail++; $display("FAIL reset_data got %h want 0000", data); end
    n_checks++; if (ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bias = BIAS_ZERO;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    send_beats(16'h8888, 1'b0);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_t1 got %b want 0", valid); end
    step();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_t2 got %b want 1", valid); end
    n_checks++; if (data !== 16'h8888) begin n_fail++; $display("FAIL basic_data got %h want 8888", data); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b want 0", busy); end
    n_checks++; if (data !== 16'h8888) begin n_fail++; $display("FAIL basic_data_kept got %h want 8888", data); end
  endtask

  task automatic test_bias_sat();
    bias = BIAS_MIX;
    pulse_start();
    send_beats(16'h8888, 1'b0);
    step();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bias_valid got %b want 1", valid); end
    n_checks++; if (data !== 16'h98F0) begin n_fail++; $display("FAIL bias_data got %h want 98f0", data); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL bias_ovf got %b want 1", ovf); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL bias_ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid_idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (data !== 16'h0) begin n_fail++; $display("FAIL rst_idle_data got %h want 0000", data); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_idle_ovf got %b want 0", ovf); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_gaps();
    bias = BIAS_ZERO;
    // Beats offered in IDLE must be dropped.
    wx_valid = 1'b1; wx = 16'hFFFF;
    step(); step();
    wx_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_busy got %b want 0", busy); end
    pulse_start();
    send_beats(16'h8888, 1'b1);
    // A beat during BIAS must also be dropped.
    wx_valid = 1'b1; wx = 16'hFFFF;
    step();
    wx_valid = 1'b0;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid got %b want 1", valid); end
    n_checks++; if (data !== 16'h8888) begin n_fail++; $display("FAIL gaps_data got %h want 8888", data); end
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bias = BIAS_MIX;
    pulse_start();
    send_beats(16'h8888, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 1", i, valid); end
      n_checks++; if (data !== 16'h98F0) begin n_fail++; $display("FAIL hold_data[%0d] got %h want 98f0", i, data); end
    end
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0; ready = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b want 0", valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_clr got %b want 0", ovf); end
    bias = BIAS_ZERO;
    send_beats(16'h1111, 1'b0);
    step();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2 got %b want 1", valid); end
    n_checks++; if (data !== 16'h1111) begin n_fail++; $display("FAIL b2b_data2 got %h want 1111", data); end
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bias = BIAS_ZERO;
    pulse_start();
    wx_valid = 1'b1; wx = 16'hFFFF;
    step(); step();
    wx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_op_busy got %b want 0", busy); end
    rst_n = 1'b1;
    step();
    pulse_start();
    send_beats(16'h8888, 1'b0);
    step();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rerun_valid got %b want 1", valid); end
    n_checks++; if (data !== 16'h8888) begin n_fail++; $display("FAIL rerun_data got %h want 8888", data); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rerun_ovf got %b want 0", ovf); end
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_sat();
    test_reset_mid_idle();
    test_gaps();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
